lane_signal_sequencer: RTL and testbench
========================================

# lane_signal_sequencer

Consumes the one-hot lane grant produced by the mode-based lane arbiter and drives the per-lane traffic heads through green, yellow and all-red clearance. While a phase runs it holds off further grants. At the end of each phase it returns a one-cycle `done` so the arbiter side can re-evaluate demand. It is the downstream, receiving end of the arbiter's `sin`/`aslane` interface and sits between the arbiter and the lamp drivers.

## Interface
- `TW`, 8: width of the phase timer.
- `GREEN_MIN`, 4: minimum green in cycles (mode 10). Constraint: ≥1.
- `GREEN_MAX`, 10: maximum green in cycles; fixed green in mode 01. Constraint: GREEN_MIN ≤ GREEN_MAX ≤ 2^TW−1.
- `YELLOW_T`, 3: yellow duration in cycles. Constraint: ≥1.
- `ALLRED_T`, 2: all-red clearance in cycles. Constraint: ≥1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `sin`  in  2  mode: 00 = hold all-red, 01 = fixed-time, 10 = actuated, 11 = treated as 00.
- `aslane`  in  4  grant from the arbiter; must be one-hot or zero.
- `lane`  in  4  live per-lane demand; used for gap-out in mode 10.
- `green`  out  4  per-lane green lamp, registered.
- `yellow`  out  4  per-lane yellow lamp, registered.
- `red`  out  4  per-lane red lamp, registered; always equals ~(green|yellow).
- `busy`  out  1  high in GREEN, YELLOW and ALLRED.
- `done`  out  1  one-cycle pulse on the first IDLE cycle after ALLRED.
- `err`  out  1  one-cycle pulse when an illegal multi-hot grant is sampled.

## Operation
- **States:** IDLE, GREEN, YELLOW, ALLRED.
- **Internal registers:** `cur` (4-bit latched grant) and `cnt` (TW bits).
- **Reset** (`rst_n`=0 at an edge), regardless of current state:
  - state → IDLE, `cur`=0, `cnt`=0.
  - `green`=0000, `yellow`=0000, `red`=1111.
  - `busy`=0, `done`=0, `err`=0.
- **IDLE:** all red.
  - Valid mode (`sin`∈{01,10}) and `aslane` one-hot: latch `cur`=`aslane`, set `cnt`=1, go to GREEN.
  - Valid mode and `aslane` has ≥2 bits set: `err`=1 for one cycle, stay in IDLE.
  - `aslane`=0, or `sin`∈{00,11}: stay in IDLE; no error is raised.
- **GREEN:** `green`=`cur`. `cnt` increments each cycle, saturating at 2^TW−1. Go to YELLOW with `cnt`=1 at the end of any cycle where one of these holds:
  - (a) `cnt`==GREEN_MAX (max-out, both modes).
  - (b) `sin`==10, `cnt`≥GREEN_MIN and `lane`&`cur`==0 (gap-out).
  - (c) `sin`∉{01,10} (safe termination on a mode drop).
- **YELLOW:** `yellow`=`cur`. Go to ALLRED after YELLOW_T cycles.
- **ALLRED:** all red. Go to IDLE after ALLRED_T cycles. On entry to IDLE, `done`=1 for one cycle and `cur` is cleared.
- **Grant changes outside IDLE:** changes on `aslane` during GREEN, YELLOW or ALLRED are ignored. A mode change during YELLOW or ALLRED does not shorten the clearance.
- **Output invariants:** never more than one lane non-red. `green` and `yellow` are never both set for the same lane.

## Timing
- **Grant to green:** latency is 1 cycle. A grant sampled at edge N gives `green` high from N+1.
- **Mode 01:** green lasts exactly GREEN_MAX cycles.
- **Mode 10:** green lasts between GREEN_MIN and GREEN_MAX cycles. If demand is low when sampled in cycle k≥GREEN_MIN, green ends after cycle k.
- **Yellow and clearance:** yellow lasts exactly YELLOW_T cycles, then all-red exactly ALLRED_T cycles.
- **`busy` duration:** high for green + YELLOW_T + ALLRED_T cycles.
- **Back-to-back phases:** the `done` cycle is an IDLE cycle and samples `aslane`. The minimum red-to-green gap between phases is therefore ALLRED_T+1 cycles.
- **Error flag:** `err` is registered and asserts the cycle after the bad grant is sampled.

## Test plan
All scenarios use the default parameters.

- **Reset mid-phase:** drive `rst_n` low for 1 edge during GREEN → next cycle `red`=1111, `green`=0000, `busy`=0, `done`=0. A grant sampled after release starts a fresh phase.
- **Fixed-time phase:** `sin`=01, `aslane`=0100 for one cycle →
  - `green`=0100 for 10 cycles, then `yellow`=0100 for 3 cycles, then `red`=1111 for 2 cycles.
  - `done` pulses once; `busy` is high for exactly 15 cycles.
- **Actuated gap-out and max-out:** `sin`=10, `aslane`=0001, with three demand cases:
  - `lane[0]`=0 throughout → green lasts 4 cycles.
  - `lane[0]`=1 throughout → green lasts 10 cycles.
  - `lane[0]` drops in green cycle 6 → green lasts 6 cycles.
- **Illegal grant:** `sin`=01, `aslane`=1010 → `err` pulses once, `red` stays 1111, `busy`=0.
- **Mode drop and hold:** switch `sin` to 00 in green cycle 2 of a mode-01 phase → `yellow` starts in cycle 3, followed by the full 3+2 clearance and `done`. Then `sin`=00 with `aslane`=1000 → no phase starts and no `err`.
- **Back-to-back grant:** hold `aslane`=1000 with `sin`=01 → after `done`, `green`=1000 reasserts on the next cycle; the red gap is exactly 3 cycles.

Source files
------------

// File: rtl/lane_signal_sequencer.sv
// Lane signal sequencer: turns a one-hot arbiter grant into a green/yellow/all-red
// phase on the granted lane, holding off new grants until the phase completes.
module lane_signal_sequencer #(
  parameter int TW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sin,
  input  logic [3:0] aslane,
  input  logic [3:0] lane,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;
  localparam logic [1:0] ALLRED = 2'd3;

  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] G_MIN   = TW'(GREEN_MIN);
  localparam logic [TW-1:0] G_MAX   = TW'(GREEN_MAX);
  localparam logic [TW-1:0] Y_T     = TW'(YELLOW_T);
  localparam logic [TW-1:0] AR_T    = TW'(ALLRED_T);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    cur_reg, cur_next;
  logic [TW-1:0] cnt_reg, cnt_next;
  logic [3:0]    green_reg, yellow_reg, red_reg;
  logic [3:0]    green_next, yellow_next, red_next;
  logic          busy_reg, done_reg, err_reg;
  logic          busy_next, done_next, err_next;

  logic          mode_ok, grant_one, grant_multi, green_end;
  logic [TW-1:0] cnt_inc;

  assign mode_ok     = (sin == 2'b01) || (sin == 2'b10);
  assign grant_multi = (aslane & (aslane - 4'd1)) != 4'd0;
  assign grant_one   = (aslane != 4'd0) && !grant_multi;
  assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + ONE;

  // Max-out, gap-out (actuated only) or a dropped mode all end the green.
  assign green_end = (cnt_reg == G_MAX)
                  || ((sin == 2'b10) && (cnt_reg >= G_MIN) && ((lane & cur_reg) == 4'd0))
                  || !mode_ok;

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mode_ok && grant_one) begin
          state_next = GREEN;
          cur_next   = aslane;
          cnt_next   = ONE;
        end else if (mode_ok && grant_multi) begin
          err_next = 1'b1;
        end
      end
      GREEN: begin
        if (green_end) begin
          state_next = YELLOW;
          cnt_next   = ONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      YELLOW: begin
        if (cnt_reg == Y_T) begin
          state_next = ALLRED;
          cnt_next   = ONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ALLRED: begin
        if (cnt_reg == AR_T) begin
          state_next = IDLE;
          cur_next   = 4'd0;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cur_next   = 4'd0;
        cnt_next   = '0;
      end
    endcase
  end

  // Lamps are derived from the next state so they line up with it after the edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lamp
      assign green_next[gi]  = (state_next == GREEN) && cur_next[gi];
      assign yellow_next[gi] = (state_next == YELLOW) && cur_next[gi];
      assign red_next[gi]    = ~(green_next[gi] | yellow_next[gi]);
    end
  endgenerate

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cur_reg    <= 4'd0;
      cnt_reg    <= '0;
      green_reg  <= 4'd0;
      yellow_reg <= 4'd0;
      red_reg    <= 4'hF;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cur_reg    <= cur_next;
      cnt_reg    <= cnt_next;
      green_reg  <= green_next;
      yellow_reg <= yellow_next;
      red_reg    <= red_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign green  = green_reg;
  assign yellow = yellow_reg;
  assign red    = red_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_lane_signal_sequencer.sv
// Bench for lane_signal_sequencer: table of phase scenarios expanded into per-cycle
// expected lamp/flag vectors, queued at drive time and compared after each edge.
module tb_lane_signal_sequencer;

  localparam int YT = 3;
  localparam int AT = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] sin;
  logic [3:0] aslane;
  logic [3:0] lane;
  logic [3:0] green, yellow, red;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  typedef struct {
    string      name;
    logic [1:0] sin;
    logic [3:0] grant;
    int         drop;   // first green cycle with no demand on the lane
    int         mdrop;  // first cycle with sin forced to 00
    int         glen;   // expected green length in cycles
    bit         bad;
    bit         b2b;
  } scn_t;

  scn_t tbl[7];

  lane_signal_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .aslane(aslane), .lane(lane),
    .green(green), .yellow(yellow), .red(red),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic [3:0] g, input logic [3:0] y,
                                     input logic b, input logic d, input logic e);
    return {g, y, ~(g | y), b, d, e};
  endfunction

  // Expected outputs in cycle idx of a phase whose grant was sampled in cycle 0.
  function automatic logic [14:0] pexp(input logic [3:0] grant, input int glen, input int idx);
    if (idx <= glen)           return mk(grant, 4'h0, 1'b1, 1'b0, 1'b0);
    if (idx <= glen + YT)      return mk(4'h0, grant, 1'b1, 1'b0, 1'b0);
    if (idx <= glen + YT + AT) return mk(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    if (idx == glen + YT + AT + 1) return mk(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    return mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic tick(input string name, input logic [14:0] e);
    logic [14:0] want, got;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = {green, yellow, red, busy, done, err};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got g/y/r/busy/done/err=%b required %b", name, got, want);
    end else begin
      $display("%s: g=%b y=%b r=%b busy=%b done=%b err=%b", name, green, yellow, red, busy, done, err);
    end
  endtask

  task automatic run_scn(input scn_t s);
    sin = s.sin; aslane = s.grant; lane = 4'h0;
    if (s.bad) begin
      tick(s.name, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b1));
      aslane = 4'h0;
      tick(s.name, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
      return;
    end
    tick(s.name, pexp(s.grant, s.glen, 1));
    for (int k = 1; k <= s.glen + YT + AT; k++) begin
      sin    = (k >= s.mdrop) ? 2'b00 : s.sin;
      aslane = s.b2b ? s.grant : ~s.grant;  // multi-hot noise must be ignored
      lane   = (k >= s.drop) ? 4'h0 : s.grant;
      tick(s.name, pexp(s.grant, s.glen, k + 1));
    end
    aslane = s.b2b ? s.grant : 4'h0;
    if (s.b2b) tick(s.name, mk(s.grant, 4'h0, 1'b1, 1'b0, 1'b0));
    else       tick(s.name, pexp(s.grant, s.glen, s.glen + YT + AT + 2));
  endtask

  initial begin
    tbl[0] = '{"fixed_time",   2'b01, 4'b0100, 1,  99, 10, 1'b0, 1'b0};
    tbl[1] = '{"act_gap_out",  2'b10, 4'b0001, 1,  99, 4,  1'b0, 1'b0};
    tbl[2] = '{"act_max_out",  2'b10, 4'b0001, 99, 99, 10, 1'b0, 1'b0};
    tbl[3] = '{"act_drop6",    2'b10, 4'b0001, 6,  99, 6,  1'b0, 1'b0};
    tbl[4] = '{"illegal",      2'b01, 4'b1010, 1,  99, 0,  1'b1, 1'b0};
    tbl[5] = '{"mode_drop",    2'b01, 4'b0010, 99, 2,  2,  1'b0, 1'b0};
    tbl[6] = '{"back_to_back", 2'b01, 4'b1000, 99, 99, 10, 1'b0, 1'b1};

    rst_n = 1'b0; sin = 2'b01; aslane = 4'b0001; lane = 4'h0;
    tick("reset", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    tick("reset", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1; aslane = 4'h0;
    tick("idle", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 6; i++) run_scn(tbl[i]);

    sin = 2'b00; aslane = 4'b1000;
    tick("hold_00", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    sin = 2'b11; aslane = 4'b1010;
    tick("hold_11", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    sin = 2'b10; aslane = 4'h0;
    tick("no_grant", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));

    // Back-to-back leaves the DUT in a fresh green; reset it mid-phase.
    run_scn(tbl[6]);
    rst_n = 1'b0;
    tick("reset_mid", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1; aslane = 4'h0;
    tick("after_reset", mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    run_scn(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
